// File: rtl/scan_decoder.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with a free-running scan mode.
// Optional macro SCAN_DECODER_BLANK_EN inserts one blank cycle per scan step.
module scan_decoder #(
  parameter int SEL_W      = 4,
  parameter int DIV_W      = 16,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DIV_W-1:0]      div,
  input  logic [SEL_W-1:0]      last,
  output logic [(2**SEL_W)-1:0] q,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam logic [OUT_W-1:0] INACT = {OUT_W{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  function automatic logic [OUT_W-1:0] enc(input logic [SEL_W-1:0] i);
    enc = ({{(OUT_W-1){1'b0}}, 1'b1} << i) ^ INACT;
  endfunction

  state_t             r_state, w_state;
  logic [OUT_W-1:0]   r_q, w_q;
  logic [SEL_W-1:0]   r_idx, w_idx;
  logic [DIV_W-1:0]   r_pre, w_pre;
  logic               r_wrap, w_wrap;
`ifdef SCAN_DECODER_BLANK_EN
  logic               r_blank, w_blank;
`endif

  always_comb begin
    w_state = IDLE;
    w_q     = INACT;
    w_idx   = '0;
    w_pre   = '0;
    w_wrap  = 1'b0;
`ifdef SCAN_DECODER_BLANK_EN
    w_blank = 1'b0;
`endif
    if (!en) begin
      w_state = IDLE;
    end else if (!mode) begin
      w_state = DIRECT;
      w_idx   = sel;
      w_q     = enc(sel);
    end else begin
      w_state = SCAN;
      if (r_state != SCAN) begin
        w_q = enc({SEL_W{1'b0}});
      end else begin
`ifdef SCAN_DECODER_BLANK_EN
        // A blank cycle holds the old index; the new one is chosen as it ends.
        if (r_blank) begin
          w_idx = (r_wrap || (r_idx >= last)) ? {SEL_W{1'b0}} : r_idx + SEL_W'(1);
          w_q   = enc(w_idx);
        end else if (r_pre >= div) begin
          w_blank = 1'b1;
          w_idx   = r_idx;
          w_pre   = r_pre;
          w_wrap  = (r_idx >= last);
        end else begin
          w_idx = r_idx;
          w_pre = r_pre + DIV_W'(1);
          w_q   = enc(r_idx);
        end
`else
        // >= so a div lowered below the running count steps on the next edge.
        if (r_pre >= div) begin
          w_wrap = (r_idx >= last);
          w_idx  = w_wrap ? {SEL_W{1'b0}} : r_idx + SEL_W'(1);
        end else begin
          w_idx = r_idx;
          w_pre = r_pre + DIV_W'(1);
        end
        w_q = enc(w_idx);
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_q     <= INACT;
      r_idx   <= '0;
      r_pre   <= '0;
      r_wrap  <= 1'b0;
`ifdef SCAN_DECODER_BLANK_EN
      r_blank <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_q     <= w_q;
      r_idx   <= w_idx;
      r_pre   <= w_pre;
      r_wrap  <= w_wrap;
`ifdef SCAN_DECODER_BLANK_EN
      r_blank <= w_blank;
`endif
    end
  end

  assign q    = r_q;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered successor to the fixed 4-to-16 enable decoder: SEL_W-bit select to 2**SEL_W one-hot output.
- Adds a free-running scan mode that steps the active output through indices 0..last at a programmable rate.
- Used for digit/row select of multiplexed displays and as a generic registered one-hot decoder in lab datapaths.

Parameters:
- SEL_W, 4, select width; OUT_W = 2**SEL_W outputs (derived localparam, not overridable)
- DIV_W, 16, width of prescaler reload value
- ACTIVE_LOW, 0, 1 = q inverted (selected line 0, others 1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  1 = decoder active; 0 = all outputs inactive
- mode  input  1  0 = direct decode of sel; 1 = auto-scan
- sel  input  SEL_W  direct-mode index
- div  input  DIV_W  scan dwell: each index held div+1 clk cycles
- last  input  SEL_W  highest scan index (scan covers 0..last)
- q  output  OUT_W  registered one-hot (polarity per ACTIVE_LOW)
- idx  output  SEL_W  index currently driven on q
- wrap  output  1  one-cycle pulse when scan steps from last to 0

Behaviour:
- Inactive pattern: all 0 (ACTIVE_LOW=0) or all 1 (ACTIVE_LOW=1).
- Reset (async, immediate): q = inactive, idx = 0, wrap = 0, prescaler = 0, state IDLE.
- States: IDLE, DIRECT, SCAN; evaluated every rising edge.
  - en=0 -> IDLE; en=1,mode=0 -> DIRECT; en=1,mode=1 -> SCAN.
- IDLE: q inactive, idx = 0, prescaler cleared, wrap = 0.
- DIRECT: q = onehot(sel), idx = sel; latency exactly 1 cycle from sel change; prescaler held at 0; wrap = 0.
- SCAN entry from IDLE/DIRECT: first SCAN cycle drives idx = 0, prescaler = 0.
- SCAN steady:
  - Prescaler counts 0..div.
  - At count == div: prescaler -> 0 and idx advances.
  - idx >= last at step: idx -> 0 and wrap = 1 for that one cycle.
  - Otherwise idx + 1.
  - div = 0 -> idx advances every cycle.
- last = 0 -> idx stays 0; wrap pulses every div+1 cycles.
- last lowered below current idx mid-scan -> next step wraps to 0 with wrap pulse; no out-of-range index is ever produced.
- div changed mid-dwell -> new value compared from the next cycle; if prescaler already > new div, step occurs on next cycle.
- q always equals onehot(idx) outside IDLE (subject to the Optional Feature); never more than one active bit.
- Mode switch SCAN -> DIRECT: q = onehot(sel) next cycle; scan position discarded.
- Reset asserted mid-scan: outputs inactive immediately. After release, scan restarts at idx 0.

Optional Feature:
- Macro: SCAN_DECODER_BLANK_EN.
- Defined:
  - In SCAN, every index step inserts one blank cycle: q = inactive, idx keeps the old value.
  - The new index is driven the following cycle.
  - The prescaler does not count during the blank cycle, so the period per index = div+2.
  - wrap pulses on the blank cycle preceding index 0.
  - DIRECT and IDLE are unaffected.
- Undefined: no blank cycle; q switches directly between indices; period = div+1.

Test Plan:
- Reset, en=0 -> q=16'h0000, idx=0, wrap=0. Assert rst mid-scan at idx=5 -> q=16'h0000 without waiting for a clk edge.
- en=1, mode=0, sweep sel 0..15 (one per cycle) -> q one cycle later = 16'h0001..16'h8000; en=0 -> q=16'h0000 next cycle.
- en=1, mode=1, div=2, last=3 -> idx sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; wrap high only on the cycle idx returns to 0 (every 12 cycles).
- Scan with div=0, last=15, lower last to 4 while idx=9 -> next cycle idx=0 with wrap=1, then 0..4 repeating.
- ACTIVE_LOW=1, mode=0, sel=4'hA -> q=16'hFBFF; en=0 -> q=16'hFFFF.
- With SCAN_DECODER_BLANK_EN, div=1, last=1 -> q: 0001,0001,0000,0002,0002,0000(wrap=1),0001...; without macro -> 0001,0001,0002,0002,0001...
